// File: rtl/display_pkg.sv
// display_pkg: scheduler state type and a ms-to-cycles helper (clk_per in ns).
package display_pkg;
  typedef enum logic [1:0] {IDLE, SWITCH, SHOW} sched_state_t;
  function automatic int ms_to_cycles(input int ms, input int clk_per);
    return int'((longint'(ms) * longint'(1_000_000)) / longint'(clk_per));
  endfunction
endpackage

// File: rtl/rr_picker.sv
// rr_picker: circular priority search of req starting after idx and ending at idx.
module rr_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] idx,
  output logic [$clog2(N)-1:0] nxt,
  output logic                 hit
);
  localparam int IW = $clog2(N);
  always_comb begin
    nxt = '0;
    hit = 1'b0;
    for (int k = N; k > 0; k--)
      if (req[IW'((int'(idx) + k) % N)]) begin
        hit = 1'b1;
        nxt = IW'((int'(idx) + k) % N);
      end
  end
endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin, dwell-timed mux of digit sources onto one seven_segment.
// Optional source-index tag overlay on the top digit with DISPLAY_SCHED_TAG_EN.
module display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SOURCES  = 4,
  parameter int NUM_SEGMENTS = 4,
  parameter int DWELL_CYCLES = 200_000_000,
  parameter int TAG_CYCLES   = 50_000_000
) (
  input  logic                                         clk,
  input  logic                                         CPU_RESETN,
  input  logic [NUM_SOURCES-1:0]                       src_req,
  input  logic [NUM_SOURCES-1:0][NUM_SEGMENTS-1:0][3:0] src_encoded,
  input  logic [NUM_SOURCES-1:0][NUM_SEGMENTS-1:0]     src_digit_point,
  input  logic                                         advance,
  input  logic                                         hold,
  output logic [NUM_SEGMENTS-1:0][3:0]                 encoded,
  output logic [NUM_SEGMENTS-1:0]                      digit_point,
  output logic [$clog2(NUM_SOURCES)-1:0]               src_sel,
  output logic [NUM_SOURCES-1:0]                       src_grant,
  output logic                                         blank
);
  localparam int SW = $clog2(NUM_SOURCES);
  localparam int DW = $clog2(DWELL_CYCLES);
  sched_state_t                 state_q, state_d;
  logic [SW-1:0]                src_sel_q, src_sel_d, pick;
  logic [NUM_SOURCES-1:0]       src_grant_q, src_grant_d;
  logic                         blank_q, blank_d, hit;
  logic [DW-1:0]                dwell_q, dwell_d;
  logic [NUM_SEGMENTS-1:0][3:0] encoded_q, encoded_d;
  logic [NUM_SEGMENTS-1:0]      digit_point_q, digit_point_d;
`ifdef DISPLAY_SCHED_TAG_EN
  localparam int TW = $clog2(TAG_CYCLES + 1);
  logic [TW-1:0] tag_q, tag_d;
  logic          tag_on;
`endif
  // with nothing shown the search wraps to start at source 0
  rr_picker #(.N(NUM_SOURCES)) u_picker (
    .req (src_req),
    .idx (|src_grant_q ? src_sel_q : SW'(NUM_SOURCES - 1)),
    .nxt (pick),
    .hit (hit)
  );
  always_comb begin
    state_d       = state_q;
    src_sel_d     = src_sel_q;
    src_grant_d   = src_grant_q;
    blank_d       = blank_q;
    dwell_d       = dwell_q;
    encoded_d     = state_q == SHOW ? src_encoded[src_sel_q] : (state_q == SWITCH && hit) ? encoded_q : '0;
    digit_point_d = state_q == SHOW ? src_digit_point[src_sel_q] : (state_q == SWITCH && hit) ? digit_point_q : '0;
    unique case (state_q)
      IDLE: if (|src_req) state_d = SWITCH;
      SWITCH: begin
        state_d          = hit ? SHOW : IDLE;
        src_sel_d        = hit ? pick : '0;
        src_grant_d      = '0;
        src_grant_d[pick] = hit;
        blank_d          = !hit;
        dwell_d          = '0;
      end
      SHOW:
        if (!src_req[src_sel_q] || advance || (!hold && dwell_q == DW'(DWELL_CYCLES - 1))) state_d = SWITCH;
        else if (!hold) dwell_d = dwell_q + 1'b1;
      default: state_d = IDLE;
    endcase
`ifdef DISPLAY_SCHED_TAG_EN
    tag_on = state_q == SHOW && tag_q != TW'(TAG_CYCLES);
    tag_d  = state_q == SWITCH ? '0 : tag_on ? tag_q + 1'b1 : tag_q;
    if (tag_on) begin
      encoded_d[NUM_SEGMENTS-1]     = 4'(src_sel_q);
      digit_point_d[NUM_SEGMENTS-1] = 1'b1;
    end
`endif
  end
  always_ff @(posedge clk or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      state_q       <= IDLE;
      src_sel_q     <= '0;
      src_grant_q   <= '0;
      blank_q       <= 1'b1;
      dwell_q       <= '0;
      encoded_q     <= '0;
      digit_point_q <= '0;
`ifdef DISPLAY_SCHED_TAG_EN
      tag_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      src_sel_q     <= src_sel_d;
      src_grant_q   <= src_grant_d;
      blank_q       <= blank_d;
      dwell_q       <= dwell_d;
      encoded_q     <= encoded_d;
      digit_point_q <= digit_point_d;
`ifdef DISPLAY_SCHED_TAG_EN
      tag_q         <= tag_d;
`endif
    end
  assign encoded     = encoded_q;
  assign digit_point = digit_point_q;
  assign src_sel     = src_sel_q;
  assign src_grant   = src_grant_q;
  assign blank       = blank_q;
endmodule
